// File: rtl/mips_instr_memory_responder.sv
// Instruction-fetch responder for mips_cpu_harvard: loadable program store plus
// end-of-program (fetch of address 0), address-fault and cycle-budget detection.
module mips_instr_memory_responder #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter int          DEPTH        = 64,
  parameter int          TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] register_v0,
  output logic        done,
  output logic [31:0] result,
  output logic        timeout,
  output logic        addr_fault,
  output logic [15:0] cycles
);

  localparam int              PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0]     WINDOW_BYTES = 32'(4 * DEPTH);
  localparam logic [15:0]     TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DEPTH - 1);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [DEPTH-1:0] valid_reg, valid_set;
  logic [31:0]      mem_reg [DEPTH];
  logic             done_reg, done_next;
  logic             timeout_reg, timeout_next;
  logic             fault_reg, fault_next;
  logic [31:0]      result_reg, result_next;
  logic [15:0]      cycles_reg, cycles_next;

  logic [31:0]      offset;
  logic             in_window;
  logic             fetch_fault;
  logic [PTR_W-1:0] fetch_idx;
  logic             load_fire;

  // Subtraction wraps addresses below the vector to large offsets, so a single
  // unsigned compare covers both ends of the window.
  assign offset      = instr_address - RESET_VECTOR;
  assign in_window   = (offset < WINDOW_BYTES) && (offset[1:0] == 2'b00);
  assign fetch_idx   = offset[PTR_W+1:2];
  assign fetch_fault = (instr_address != 32'd0) && !in_window;
  assign load_fire   = (state_reg == ST_LOAD) && load_valid && clk_enable;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid_set
      assign valid_set[gi] = load_fire && (ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    instr_readdata = 32'd0;
    if (state_reg != ST_LOAD && instr_address != 32'd0 && in_window && valid_reg[fetch_idx])
      instr_readdata = mem_reg[fetch_idx];
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    done_next    = done_reg;
    timeout_next = timeout_reg;
    fault_next   = fault_reg;
    result_next  = result_reg;
    cycles_next  = cycles_reg;
    case (state_reg)
      ST_LOAD: begin
        if (load_valid) begin
          ptr_next = ptr_reg + 1'b1;
          if (load_last || ptr_reg == PTR_LAST)
            state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        cycles_next = (cycles_reg == 16'hFFFF) ? cycles_reg : cycles_reg + 16'd1;
        // Completion outranks a fault, which outranks the cycle budget.
        if (instr_address == 32'd0) begin
          result_next = register_v0;
          done_next   = 1'b1;
          state_next  = ST_DONE;
        end else if (fetch_fault) begin
          fault_next = 1'b1;
          state_next = ST_FAULT;
        end else if (cycles_reg == TIMEOUT_LAST) begin
          timeout_next = 1'b1;
          state_next   = ST_FAULT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_LOAD;
      ptr_reg     <= '0;
      valid_reg   <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      fault_reg   <= 1'b0;
      result_reg  <= 32'd0;
      cycles_reg  <= 16'd0;
    end else if (clk_enable) begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      valid_reg   <= valid_reg | valid_set;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      fault_reg   <= fault_next;
      result_reg  <= result_next;
      cycles_reg  <= cycles_next;
    end
  end

  // Program words carry no reset; the valid bits decide what is visible.
  always_ff @(posedge clk) begin
    if (reset && load_fire)
      mem_reg[ptr_reg] <= load_data;
  end

  assign load_ready = (state_reg == ST_LOAD);
  assign done       = done_reg;
  assign timeout    = timeout_reg;
  assign addr_fault = fault_reg;
  assign result     = result_reg;
  assign cycles     = cycles_reg;

endmodule

// File: tb/tb_mips_instr_memory_responder.sv
// Bench for mips_instr_memory_responder: fetch expectations go through a scoreboard
// queue checked on the falling edge; flag/counter checks are inline per scenario.
module tb_mips_instr_memory_responder;

  logic        clk = 1'b0;
  logic        reset, clk_enable, load_valid, load_last;
  logic [31:0] load_data, instr_address, register_v0;
  logic        load_ready, done, timeout, addr_fault;
  logic [31:0] instr_readdata, result;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_t;
  fetch_t      exp_q[$];
  fetch_t      mon_e;
  logic [31:0] prog [64];

  mips_instr_memory_responder #(
    .RESET_VECTOR(32'hBFC00000), .DEPTH(64), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .register_v0(register_v0),
    .done(done), .result(result), .timeout(timeout),
    .addr_fault(addr_fault), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // Scoreboard: each queued fetch is compared mid-cycle while its address is held.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (instr_readdata !== mon_e.data) begin
        errors++;
        $display("FAIL fetch addr=%h got=%h exp=%h", mon_e.addr, instr_readdata, mon_e.data);
      end else
        $display("fetch addr=%h data=%h", mon_e.addr, instr_readdata);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    instr_address = a;
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic load_prog(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == n - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic set_sltu();
    prog[0] = 32'h2484000B; prog[1] = 32'h24A5004D; prog[2] = 32'h0085102B;
    prog[3] = 32'h00000008; prog[4] = 32'h24000000;
  endtask

  task automatic test_reset();
    reset = 1'b0; clk_enable = 1'b1; load_valid = 1'b0; load_last = 1'b0;
    load_data = 32'd0; instr_address = 32'hBFC00000; register_v0 = 32'd0;
    tick(); tick();
    reset = 1'b1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%b exp=1", load_ready); end
    checks++; if ({done, timeout, addr_fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {done, timeout, addr_fault}); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
  endtask

  task automatic test_load_sltu();
    set_sltu();
    instr_address = 32'hBFC00000;
    load_prog(5, 1'b1);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL sltu_load_ready got=%b exp=0", load_ready); end
    clk_enable = 1'b0;
    fetch(32'hBFC00008, 32'h0085102B); tick();
    fetch(32'hBFC00014, 32'h00000000); tick();
    fetch(32'hBFC00000, 32'h2484000B); tick();
    fetch(32'hBFC0000C, 32'h00000008); tick();
    clk_enable = 1'b1;
    checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL sltu_frozen_cycles got=%0d exp=0", cycles); end
  endtask

  task automatic test_completion();
    register_v0 = 32'd0;
    for (int i = 0; i < 6; i++) begin
      fetch(32'hBFC00000 + 32'(4 * (i % 5)), prog[i % 5]);
      tick();
    end
    checks++; if ({cycles, done} !== {16'd6, 1'b0}) begin errors++; $display("FAIL pre_done cycles/done got=%0d/%b exp=6/0", cycles, done); end
    register_v0 = 32'd1;
    fetch(32'd0, 32'd0);
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_set got=%b exp=1", done); end
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL done_result got=%h exp=1", result); end
    checks++; if (cycles !== 16'd7) begin errors++; $display("FAIL done_cycles got=%0d exp=7", cycles); end
    checks++; if ({timeout, addr_fault} !== 2'b00) begin errors++; $display("FAIL done_other_flags got=%b exp=00", {timeout, addr_fault}); end
    register_v0 = 32'h0000DEAD;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) fetch(32'hBFC00102, 32'd0);
      else            fetch(32'hBFC00008, 32'h0085102B);
      tick();
    end
    checks++; if ({done, timeout, addr_fault} !== 3'b100) begin errors++; $display("FAIL done_hold_flags got=%b exp=100", {done, timeout, addr_fault}); end
    checks++; if (result !== 32'd1) begin errors++; $display("FAIL done_hold_result got=%h exp=1", result); end
    checks++; if (cycles !== 16'd7) begin errors++; $display("FAIL done_hold_cycles got=%0d exp=7", cycles); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    load_prog(5, 1'b1);
    for (int i = 0; i < 8; i++) begin fetch(32'hBFC00004, 32'h24A5004D); tick(); end
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin fetch(32'd0, 32'd0); tick(); end
    checks++; if ({cycles, done} !== {16'd8, 1'b0}) begin errors++; $display("FAIL frozen cycles/done got=%0d/%b exp=8/0", cycles, done); end
    clk_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin fetch(32'hBFC00004, 32'h24A5004D); tick(); end
    checks++; if ({cycles, timeout} !== {16'd15, 1'b0}) begin errors++; $display("FAIL pre_timeout cycles/timeout got=%0d/%b exp=15/0", cycles, timeout); end
    fetch(32'hBFC00004, 32'h24A5004D); tick();
    checks++; if ({done, timeout, addr_fault} !== 3'b010) begin errors++; $display("FAIL timeout_flags got=%b exp=010", {done, timeout, addr_fault}); end
    checks++; if (cycles !== 16'd16) begin errors++; $display("FAIL timeout_cycles got=%0d exp=16", cycles); end
    for (int i = 0; i < 3; i++) begin fetch(32'd0, 32'd0); tick(); end
    checks++; if ({done, cycles} !== {1'b0, 16'd16}) begin errors++; $display("FAIL timeout_hold done/cycles got=%b/%0d exp=0/16", done, cycles); end
  endtask

  task automatic test_fault_misaligned();
    pulse_reset();
    load_prog(5, 1'b1);
    fetch(32'hBFC00004, 32'h24A5004D); tick();
    fetch(32'hBFC00102, 32'd0); tick();
    checks++; if ({done, timeout, addr_fault} !== 3'b001) begin errors++; $display("FAIL misaligned_flags got=%b exp=001", {done, timeout, addr_fault}); end
    checks++; if (cycles !== 16'd2) begin errors++; $display("FAIL misaligned_cycles got=%0d exp=2", cycles); end
    fetch(32'd0, 32'd0); tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fault_terminal_done got=%b exp=0", done); end
  endtask

  task automatic test_fault_window();
    pulse_reset();
    load_prog(5, 1'b1);
    fetch(32'hBFC000FC, 32'd0); tick();
    checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL window_edge_fault got=%b exp=0", addr_fault); end
    fetch(32'hBFC00100, 32'd0); tick();
    checks++; if ({done, timeout, addr_fault} !== 3'b001) begin errors++; $display("FAIL window_flags got=%b exp=001", {done, timeout, addr_fault}); end
  endtask

  task automatic test_reset_mid_run();
    pulse_reset();
    load_prog(5, 1'b1);
    for (int i = 0; i < 3; i++) begin fetch(32'hBFC00008, 32'h0085102B); tick(); end
    checks++; if (cycles !== 16'd3) begin errors++; $display("FAIL midrun_cycles got=%0d exp=3", cycles); end
    pulse_reset();
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midrun_reset_ready got=%b exp=1", load_ready); end
    checks++; if ({done, timeout, addr_fault, cycles} !== 19'd0) begin errors++; $display("FAIL midrun_reset_state got=%b/%0d exp=000/0", {done, timeout, addr_fault}, cycles); end
    prog[0] = 32'h11111111; prog[1] = 32'h22222222;
    load_prog(2, 1'b1);
    clk_enable = 1'b0;
    fetch(32'hBFC00008, 32'd0); tick();
    fetch(32'hBFC00004, 32'h22222222); tick();
    clk_enable = 1'b1;
  endtask

  task automatic test_capacity();
    pulse_reset();
    for (int i = 0; i < 64; i++) prog[i] = 32'hA5000000 | 32'(i);
    instr_address = 32'hBFC00000;
    load_prog(63, 1'b0);
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL cap_63_ready got=%b exp=1", load_ready); end
    clk_enable = 1'b0;
    fetch(32'hBFC00000, 32'd0); tick();
    clk_enable = 1'b1;
    load_valid = 1'b1; load_data = prog[63]; load_last = 1'b0;
    tick();
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL cap_64_ready got=%b exp=0", load_ready); end
    load_data = 32'hDEADBEEF;
    fetch(32'hBFC00000, 32'hA5000000); tick();
    load_valid = 1'b0;
    clk_enable = 1'b0;
    fetch(32'hBFC000FC, 32'hA500003F); tick();
    fetch(32'hBFC00000, 32'hA5000000); tick();
    fetch(32'hBFC00080, 32'hA5000020); tick();
    clk_enable = 1'b1;
    checks++; if ({addr_fault, cycles} !== {1'b0, 16'd1}) begin errors++; $display("FAIL cap_run fault/cycles got=%b/%0d exp=0/1", addr_fault, cycles); end
  endtask

  initial begin
    test_reset();
    test_load_sltu();
    test_completion();
    test_timeout();
    test_fault_misaligned();
    test_fault_window();
    test_reset_mid_run();
    test_capacity();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_memory_responder.md
Name: mips_instr_memory_responder

Overview:
- Responder for the CPU's instruction-fetch port; serves instr_readdata for a program window starting at the reset vector.
- Bench-side reusable block. It replaces hand-written per-test address decoders with a loadable program store.
- Also detects end of program, which is a fetch from address 0 after `jr $0`. At that point it captures register_v0 and reports done, timeout or fault.
- Sits between the program loader/bench and mips_cpu_harvard's instr_address/instr_readdata pins.

Parameters:
- RESET_VECTOR, 32'hBFC00000, byte address of program word 0.
- DEPTH, 64, program capacity in 32-bit words (power of two, 2..1024).
- TIMEOUT, 1024, maximum enabled RUN cycles before a timeout is declared.

Ports:
- clk  in  1  system clock, all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- clk_enable  in  1  global enable; when low, all state is frozen.
- load_valid  in  1  program word offered.
- load_data  in  32  program word.
- load_last  in  1  qualifies load_valid; marks the final program word.
- load_ready  out  1  high in LOAD state.
- instr_address  in  32  CPU fetch address.
- instr_readdata  out  32  fetched instruction (combinational).
- register_v0  in  32  CPU $v0 debug output.
- done  out  1  program completed (sticky).
- result  out  32  register_v0 captured at completion.
- timeout  out  1  cycle budget exhausted (sticky).
- addr_fault  out  1  illegal fetch address (sticky).
- cycles  out  16  enabled RUN cycles elapsed; saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to LOAD; load pointer = 0; all per-word valid bits cleared.
  - done=0, timeout=0, addr_fault=0, result=0, cycles=0.
  - Applies from any state, including mid-load or mid-run.
- clk_enable==0: no state, pointer, memory, counter or flag changes. instr_readdata stays combinational.
- State LOAD:
  - load_ready=1.
  - On load_valid && clk_enable, load_data is written to mem[ptr], valid[ptr] is set, and ptr increments.
  - Transition to RUN on the next cycle if load_last is set with that word, or if ptr reaches DEPTH-1.
  - instr_readdata=0 throughout LOAD.
- State RUN:
  - load_ready=0; load_valid is ignored.
  - Word index = (instr_address - RESET_VECTOR) >> 2.
  - In window means RESET_VECTOR <= instr_address < RESET_VECTOR + 4*DEPTH, with instr_address[1:0]==0.
  - In window: instr_readdata = valid[idx] ? mem[idx] : 0. An unloaded word reads as a NOP.
  - instr_address == 0 returns 0 (NOP).
  - cycles increments on every enabled RUN cycle.
  - Completion: instr_address == 0 at an enabled edge sets result <= register_v0 and done <= 1, then goes to DONE.
  - Fault: instr_address is non-zero and either out of window or misaligned at an enabled edge. This sets addr_fault <= 1 and goes to FAULT.
  - Timeout: cycles == TIMEOUT-1 at an enabled edge with no completion sets timeout <= 1 and goes to FAULT.
  - Priority in the same cycle: completion > addr_fault > timeout.
- State DONE / FAULT:
  - Terminal until reset; all flags, result and cycles are held.
  - instr_readdata follows the RUN decode rules, so the CPU keeps fetching NOPs.
- Exactly one of done, timeout or addr_fault is ever set per run.
- Memory is a register array; no read latency.

Test Plan:
- Load sltu program:
  - Words: 0x2484000B, 0x24A5004D, 0x0085102B, 0x00000008, 0x24000000 (last on word 5).
  - Expect load_ready=0 one cycle after the last word.
  - instr_address=0xBFC00008 -> instr_readdata=0x0085102B.
  - instr_address=0xBFC00014 (unloaded) -> 0.
- Completion: in RUN, drive register_v0=1 and instr_address=0 at cycle 7 -> done=1, result=1, cycles=7, timeout=0, addr_fault=0; all held for 10 further cycles.
- Timeout: TIMEOUT=16, address never reaches 0 -> timeout=1 after 16 enabled RUN cycles, done=0; deasserting clk_enable for 5 cycles mid-run delays this by exactly 5 cycles.
- Address faults:
  - instr_address=0xBFC00102 (misaligned) -> addr_fault=1, state FAULT.
  - Separately, 0xBFC00100 with DEPTH=64 (out of window) -> addr_fault=1.
- Reset mid-run: assert reset low for one edge during RUN -> load_ready=1, done/timeout/addr_fault/cycles=0; a reload of 2 words followed by a fetch of 0xBFC00008 -> 0 (valid bits cleared).
- Capacity: offer 64 words without load_last -> word 64 is accepted, then LOAD exits; a 65th load_valid is ignored; 0xBFC000FC returns the 64th word.
